// File: rtl/layer_compositor.sv
// Layer compositor: priority merge of sprite layers with colour-key transparency,
// ground/sky fill, and a frame-stepped global fade. Optional macro: LAYER_COLLIDE_EN.
module layer_compositor #(
    parameter int                    NUM_LAYERS  = 4,
    parameter int                    COLOR_W     = 8,
    parameter int                    GROUND_Y    = 416,
    parameter logic [3*COLOR_W-1:0]  KEY_COLOR   = 24'hFF00FF,
    parameter int                    FADE_STEP   = 2,
    parameter int                    HOLD_FRAMES = 30
) (
    input  logic                            Clk,
    input  logic                            Reset_n,
    input  logic                            pixel_valid,
    input  logic                            frame_start,
    input  logic [9:0]                      DrawX,
    input  logic [9:0]                      DrawY,
    input  logic [NUM_LAYERS-1:0]           layer_hit,
    input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_pix,
    input  logic [3*COLOR_W-1:0]            ground,
    input  logic [3*COLOR_W-1:0]            bg_color,
    input  logic                            fade_start,
    output logic [COLOR_W-1:0]              Red,
    output logic [COLOR_W-1:0]              Green,
    output logic [COLOR_W-1:0]              Blue,
    output logic                            out_valid,
    output logic                            fade_busy,
    output logic                            fade_black,
    output logic [NUM_LAYERS-1:0]           collide
);

    localparam int         PIX_W     = 3 * COLOR_W;
    localparam int         HOLD_W    = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);
    localparam logic [4:0] LEVEL_MAX = 5'd16;
    localparam logic [4:0] STEP      = 5'(FADE_STEP);

    typedef enum logic [1:0] {IDLE, FADE_OUT, BLACK, FADE_IN} fade_state_t;

    genvar gi;

    // ---------------- stage 1: layer select ----------------
    logic [NUM_LAYERS-1:0] opaque;

    generate
        for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_opaque
            assign opaque[gi] = layer_hit[gi] && (layer_pix[gi*PIX_W +: PIX_W] != KEY_COLOR);
        end
    endgenerate

    logic [PIX_W-1:0] sel_next;
    logic [PIX_W-1:0] sel_reg;
    logic             valid1_reg;

    // Walk from lowest to highest priority so the lowest-index opaque layer wins.
    always_comb begin
        sel_next = (DrawY >= 10'(GROUND_Y)) ? ground : bg_color;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                sel_next = layer_pix[i*PIX_W +: PIX_W];
            end
        end
        if (!pixel_valid) begin
            sel_next = '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sel_reg    <= '0;
            valid1_reg <= 1'b0;
        end else begin
            sel_reg    <= sel_next;
            valid1_reg <= pixel_valid;
        end
    end

    // ---------------- fade state machine ----------------
    fade_state_t       state_reg, state_next;
    logic [4:0]        level_reg, level_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic [5:0]        level_up;

    assign level_up = {1'b0, level_reg} + {1'b0, STEP};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
            level_reg <= LEVEL_MAX;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            level_reg <= level_next;
            hold_reg  <= hold_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        level_next = level_reg;
        hold_next  = hold_reg;
        case (state_reg)
            IDLE: begin
                // Entry is not frame-gated; the first decrement waits for the next frame_start.
                level_next = LEVEL_MAX;
                if (fade_start) begin
                    state_next = FADE_OUT;
                end
            end
            FADE_OUT: begin
                if (frame_start) begin
                    if (level_reg <= STEP) begin
                        level_next = '0;
                        hold_next  = '0;
                        state_next = BLACK;
                    end else begin
                        level_next = level_reg - STEP;
                    end
                end
            end
            BLACK: begin
                if (frame_start) begin
                    hold_next = hold_reg + 1'b1;
                    if (int'(hold_reg) + 1 >= HOLD_FRAMES) begin
                        state_next = FADE_IN;
                    end
                end
            end
            FADE_IN: begin
                if (frame_start) begin
                    if (level_up >= 6'(LEVEL_MAX)) begin
                        level_next = LEVEL_MAX;
                        state_next = IDLE;
                    end else begin
                        level_next = level_up[4:0];
                    end
                end
            end
            default: begin
                state_next = IDLE;
                level_next = LEVEL_MAX;
            end
        endcase
    end

    assign fade_busy  = (state_reg != IDLE);
    assign fade_black = (state_reg == BLACK);

    // ---------------- stage 2: brightness scale ----------------
    logic [2:0][COLOR_W+4:0] prod;
    logic [PIX_W-1:0]        rgb_next;
    logic [PIX_W-1:0]        rgb_reg;
    logic                    out_valid_reg;

    generate
        for (gi = 0; gi < 3; gi++) begin : g_scale
            assign prod[gi] = {5'b0, sel_reg[gi*COLOR_W +: COLOR_W]} * {{COLOR_W{1'b0}}, level_reg};
            assign rgb_next[gi*COLOR_W +: COLOR_W] = valid1_reg ? prod[gi][COLOR_W+3:4] : '0;
        end
    endgenerate

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rgb_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            rgb_reg       <= rgb_next;
            out_valid_reg <= valid1_reg;
        end
    end

    assign Red       = rgb_reg[3*COLOR_W-1 -: COLOR_W];
    assign Green     = rgb_reg[2*COLOR_W-1 -: COLOR_W];
    assign Blue      = rgb_reg[COLOR_W-1:0];
    assign out_valid = out_valid_reg;

    // ---------------- optional per-frame collision flags ----------------
`ifdef LAYER_COLLIDE_EN
    logic [NUM_LAYERS-1:0] overlap;
    logic [NUM_LAYERS-1:0] collide_reg;

    generate
        for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_collide
            assign overlap[gi] = opaque[gi] && (|(opaque & ~(NUM_LAYERS'(1) << gi)));
        end
    endgenerate

    // A hit in the frame_start cycle survives the clear: that pixel belongs to the new frame.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            collide_reg <= '0;
        end else begin
            collide_reg <= (frame_start ? '0 : collide_reg) | (pixel_valid ? overlap : '0);
        end
    end

    assign collide = collide_reg;
`else
    assign collide = '0;
`endif

    // DrawX is carried for interface compatibility; the product's guard bits are intentionally dropped.
    logic unused_ok;
    assign unused_ok = &{1'b0, DrawX, prod};

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: driver queues expected pixels, a forked monitor checks them.
module tb_layer_compositor;

    localparam int NL = 4;
    localparam int CW = 8;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              pixel_valid = 1'b0;
    logic              frame_start = 1'b0;
    logic              fade_start = 1'b0;
    logic [9:0]        DrawX = '0;
    logic [9:0]        DrawY = '0;
    logic [NL-1:0]     layer_hit = '0;
    logic [NL*3*CW-1:0] layer_pix = '0;
    logic [3*CW-1:0]   ground = '0;
    logic [3*CW-1:0]   bg_color = '0;
    logic [CW-1:0]     Red, Green, Blue;
    logic              out_valid, fade_busy, fade_black;
    logic [NL-1:0]     collide;

    layer_compositor dut (
        .Clk(Clk), .Reset_n(Reset_n), .pixel_valid(pixel_valid), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .layer_hit(layer_hit), .layer_pix(layer_pix),
        .ground(ground), .bg_color(bg_color), .fade_start(fade_start),
        .Red(Red), .Green(Green), .Blue(Blue), .out_valid(out_valid),
        .fade_busy(fade_busy), .fade_black(fade_black), .collide(collide)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct packed {
        int          due;
        logic        v;
        logic [23:0] rgb;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    tests = 0;
    int    fails = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end else begin
            $display("[TB] ok %s = %0h", nm, act);
        end
    endtask

    task automatic monitor();
        exp_t  e;
        string nm;
        forever begin
            @(negedge Clk);
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                tests++;
                if (e.due != cyc || out_valid !== e.v || {Red, Green, Blue} !== e.rgb) begin
                    fails++;
                    $display("FAIL %s: got valid=%0b rgb=%06h at cycle %0d, expected valid=%0b rgb=%06h at cycle %0d",
                             nm, out_valid, {Red, Green, Blue}, cyc, e.v, e.rgb, e.due);
                end else begin
                    $display("[TB] pixel %s: valid=%0b rgb=%06h", nm, out_valid, {Red, Green, Blue});
                end
            end
        end
    endtask

    // One input cycle; the expected output is due two clocks later.
    task automatic step(logic v, logic [3:0] hit, logic [95:0] pix, logic [9:0] y,
                        logic fs, logic fst, logic [23:0] ergb, string nm);
        @(negedge Clk);
        pixel_valid = v;
        layer_hit   = hit;
        layer_pix   = pix;
        DrawY       = y;
        DrawX       = DrawX + 10'd1;
        frame_start = fs;
        fade_start  = fst;
        exp_q.push_back('{due: cyc + 2, v: v, rgb: ergb});
        name_q.push_back(nm);
    endtask

    task automatic drive(logic v, logic [3:0] hit, logic [95:0] pix, logic [9:0] y,
                         logic [23:0] ergb, string nm);
        step(v, hit, pix, y, 1'b0, 1'b0, ergb, nm);
    endtask

    task automatic blank();
        step(1'b0, 4'b0000, '0, 10'd0, 1'b0, 1'b0, 24'h0, "blank");
    endtask

    task automatic frame_pulse(logic with_fade);
        step(1'b0, 4'b0000, '0, 10'd0, 1'b1, with_fade, 24'h0, "frame_start");
        blank();
    endtask

    task automatic pulse_fade();
        step(1'b0, 4'b0000, '0, 10'd0, 1'b0, 1'b1, 24'h0, "fade_start");
    endtask

    // White pixel on layer 0 scaled by the level the bench expects.
    task automatic px_level(int lvl, string nm);
        logic [7:0] c;
        c = 8'((255 * lvl) >> 4);
        drive(1'b1, 4'b0001, {72'h0, 24'hFFFFFF}, 10'd100, {c, c, c}, nm);
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        #1;
        check("reset_rgb", {8'h0, Red, Green, Blue}, 32'h0);
        check("reset_out_valid", {31'h0, out_valid}, 32'h0);
        check("reset_fade_busy", {31'h0, fade_busy}, 32'h0);
        check("reset_collide", {28'h0, collide}, 32'h0);
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;

        // Layer select
        ground   = 24'h804020;
        bg_color = 24'h5080FF;
        drive(1'b1, 4'b0110, {24'h0, 24'hABCDEF, 24'h123456, 24'h0}, 10'd100, 24'h123456, "priority");
        drive(1'b1, 4'b0001, {72'h0, 24'hFF00FF}, 10'd420, 24'h804020, "key_ground");
        drive(1'b1, 4'b0001, {72'h0, 24'hFF00FF}, 10'd100, 24'h5080FF, "key_sky");
        drive(1'b1, 4'b0000, '0, 10'd416, 24'h804020, "ground_edge");
        drive(1'b1, 4'b0000, '0, 10'd415, 24'h5080FF, "sky_edge");
        drive(1'b1, 4'b0011, {48'h0, 24'h00FF00, 24'hFF00FF}, 10'd100, 24'h00FF00, "key_skip");
        drive(1'b0, 4'b0001, {72'h0, 24'h112233}, 10'd100, 24'h000000, "blanking");
        drive(1'b1, 4'b1000, {24'hA1B2C3, 72'h0}, 10'd420, 24'hA1B2C3, "layer3");
        drive(1'b1, 4'b1111, {24'h000001, 24'h000002, 24'h000003, 24'h000000}, 10'd100, 24'h000000, "black_opaque");
        blank();

        // Collision flags
        frame_pulse(1'b0);
`ifdef LAYER_COLLIDE_EN
        check("collide_cleared", {28'h0, collide}, 32'h0);
        drive(1'b1, 4'b1001, {24'h040506, 48'h0, 24'h010203}, 10'd100, 24'h010203, "collide_px");
        blank();
        check("collide_set", {28'h0, collide}, 32'h9);
        blank();
        blank();
        check("collide_sticky", {28'h0, collide}, 32'h9);
        frame_pulse(1'b0);
        check("collide_frame_clear", {28'h0, collide}, 32'h0);
`else
        drive(1'b1, 4'b1001, {24'h040506, 48'h0, 24'h010203}, 10'd100, 24'h010203, "collide_px");
        blank();
        check("collide_tied_off", {28'h0, collide}, 32'h0);
`endif

        // Fade-out: request mid-frame, level holds until the next frame_start
        pulse_fade();
        px_level(16, "fade_req_level16");
        check("fade_busy_after_req", {31'h0, fade_busy}, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            frame_pulse(1'b0);
            px_level(16 - 2 * k, "fade_out_px");
            if (k == 4) begin
                drive(1'b1, 4'b0001, {72'h0, 24'hFFFFFF}, 10'd100, 24'h7F7F7F, "level8_ff");
            end
            check("fade_out_black", {31'h0, fade_black}, {31'h0, k == 8});
        end

        // Hold fully black; a retrigger here must be ignored
        for (int h = 1; h <= 30; h++) begin
            frame_pulse(1'b0);
            if (h == 10) begin
                pulse_fade();
            end
            if (h == 15) begin
                px_level(0, "hold_px");
            end
            check("hold_black", {31'h0, fade_black}, {31'h0, h < 30});
        end
        check("hold_exit_busy", {31'h0, fade_busy}, 32'h1);

        // Fade-in back to full brightness
        for (int k = 1; k <= 8; k++) begin
            frame_pulse(1'b0);
            px_level(2 * k, "fade_in_px");
            check("fade_in_busy", {31'h0, fade_busy}, {31'h0, k < 8});
        end

        // fade_start coincident with frame_start: no decrement on that frame
        frame_pulse(1'b1);
        px_level(16, "coincident_level16");
        check("coincident_busy", {31'h0, fade_busy}, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            frame_pulse(1'b0);
            px_level(16 - 2 * k, "coincident_fade_px");
        end
        check("coincident_black", {31'h0, fade_black}, 32'h1);
        repeat (3) blank();

        // Asynchronous reset while BLACK
        @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_reset_busy", {31'h0, fade_busy}, 32'h0);
        check("async_reset_black", {31'h0, fade_black}, 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        px_level(16, "post_reset_level16");

        repeat (3) blank();
        repeat (3) @(negedge Clk);
        check("queue_drained", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
